// File: rtl/cargo_queue_scheduler.sv
// Sequencer for the 16-entry SmartCargo queue RAM: round-robin request grant,
// fit-slot scan, end-of-queue append and head pop, with occupancy tracking.
`timescale 1ns/1ps
module cargo_queue_scheduler #(
    parameter int N_REQ = 4,
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] req_tipo,
    input  logic [2*N_REQ-1:0] req_origem,
    input  logic [2*N_REQ-1:0] req_destino,
    output logic [N_REQ-1:0]   ack,
    input  logic               pop,
    output logic               pop_ack,
    output logic [1:0]         ram_tipo,
    output logic [1:0]         ram_origem,
    output logic [1:0]         ram_destino,
    output logic               ram_weT,
    output logic               ram_fit,
    output logic               ram_shift,
    output logic [3:0]         addr_sec,
    output logic [3:0]         addr_sec_ant,
    input  logic [1:0]         sec_dest,
    input  logic [1:0]         sec_dest_ant,
    output logic [4:0]         count,
    output logic               busy,
    output logic               full
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, SCAN, WR_TOP, WR_FIT, POP} state_t;
    typedef struct packed {
        logic [1:0] tipo;
        logic [1:0] origem;
        logic [1:0] destino;
    } cargo_t;

    state_t                  state, state_nxt;
    cargo_t                  lat;
    cargo_t [N_REQ-1:0]      req_pk;
    logic   [PW-1:0]         g, rr_ptr, pick;
    logic                    any_req, take_pop, grant;
    logic                    hit, scan_last;
    logic   [1:0]            lo, hi;

    for (genvar i = 0; i < N_REQ; i++) begin : g_pack
        assign req_pk[i] = '{tipo:    req_tipo[2*i +: 2],
                             origem:  req_origem[2*i +: 2],
                             destino: req_destino[2*i +: 2]};
    end

    // Walk offsets from the far end so the lowest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx     = 0;
        any_req = 1'b0;
        pick    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (req[idx]) begin
                any_req = 1'b1;
                pick    = PW'(idx);
            end
        end
    end

    assign lo        = (sec_dest_ant < sec_dest) ? sec_dest_ant : sec_dest;
    assign hi        = (sec_dest_ant < sec_dest) ? sec_dest : sec_dest_ant;
    assign hit       = (lo < lat.origem) && (lat.origem < hi);
    assign scan_last = ({1'b0, addr_sec} == (count - 5'd1));

    assign full      = (count == 5'(DEPTH));
    assign take_pop  = (state == IDLE) && pop && (count != 5'd0);
    assign grant     = (state == IDLE) && !take_pop && any_req && !full;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take_pop)   state_nxt = POP;
                else if (grant) state_nxt = (count <= 5'd1) ? WR_TOP : SCAN;
            end
            SCAN: begin
                if (hit)            state_nxt = WR_FIT;
                else if (scan_last) state_nxt = WR_TOP;
            end
            WR_TOP, WR_FIT, POP: state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            lat      <= '0;
            g        <= '0;
            rr_ptr   <= '0;
            count    <= '0;
            addr_sec <= '0;
        end else begin
            if (grant) begin
                lat    <= req_pk[pick];
                g      <= pick;
                rr_ptr <= (pick == PW'(N_REQ - 1)) ? '0 : pick + 1'b1;
            end
            case (state)
                IDLE: addr_sec <= (grant && count > 5'd1) ? 4'd1 : 4'd0;
                SCAN: if (!hit && !scan_last) addr_sec <= addr_sec + 4'd1;
                WR_TOP, WR_FIT: begin
                    if (!full) count <= count + 5'd1;
                    addr_sec <= '0;
                end
                POP: begin
                    if (count != 5'd0) count <= count - 5'd1;
                    addr_sec <= '0;
                end
                default: addr_sec <= '0;
            endcase
        end
    end

    assign ram_weT      = (state == WR_TOP);
    assign ram_fit      = (state == WR_FIT);
    assign ram_shift    = (state == POP);
    assign pop_ack      = (state == POP);
    assign busy         = (state != IDLE);
    assign ack          = (ram_weT || ram_fit) ? (N_REQ'(1) << g) : '0;
    assign addr_sec_ant = (addr_sec == 4'd0) ? 4'd0 : addr_sec - 4'd1;
    assign ram_tipo     = lat.tipo;
    assign ram_origem   = lat.origem;
    assign ram_destino  = lat.destino;
endmodule
